// File: rtl/joy_db9md_pkg.sv
// Shared definitions for the DB9 Mega Drive joystick reader.
// This file holds the joystick word bit positions, the DB9 pin positions and the scan phase encoding.
package joy_db9md_pkg;

  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_B     = 4;
  localparam int JOY_C     = 5;
  localparam int JOY_A     = 6;
  localparam int JOY_START = 7;
  localparam int JOY_Z     = 8;
  localparam int JOY_Y     = 9;
  localparam int JOY_X     = 10;
  localparam int JOY_MODE  = 11;

  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_6     = 4;
  localparam int PIN_9     = 5;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_P0   = 4'd1,
    ST_P1   = 4'd2,
    ST_P2   = 4'd3,
    ST_P3   = 4'd4,
    ST_P4   = 4'd5,
    ST_P5   = 4'd6,
    ST_P6   = 4'd7,
    ST_P7   = 4'd8
  } state_e;

endpackage

// File: rtl/db9md_port_decode.sv
// Per-port decoder: captures the DB9 pins in the sampling phases of one scan and assembles the
// shadow joystick word. The port type (none or Atari, 3-button, 6-button) is worked out from those samples.
module db9md_port_decode
  import joy_db9md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        strobe,
  input  state_e      phase,
  input  logic [5:0]  pins,
  output logic [15:0] word,
  output logic        six
);

  logic [5:0] p0_q, p0_d;
  logic       md_q, md_d;
  logic       a_q, a_d;
  logic       start_q, start_d;
  logic       up1_q, up1_d;
  logic       down1_q, down1_d;
  logic       six_q, six_d;
  logic [3:0] ext_q, ext_d;
  logic [3:0] ext_s;

  // Sample capture: the clear at scan start wins over any strobe.
  always_comb begin
    p0_d    = p0_q;
    md_d    = md_q;
    a_d     = a_q;
    start_d = start_q;
    up1_d   = up1_q;
    down1_d = down1_q;
    six_d   = six_q;
    ext_d   = ext_q;
    if (clr) begin
      p0_d    = 6'h00;
      md_d    = 1'b0;
      a_d     = 1'b0;
      start_d = 1'b0;
      up1_d   = 1'b0;
      down1_d = 1'b0;
      six_d   = 1'b0;
      ext_d   = 4'h0;
    end else if (strobe) begin
      case (phase)
        ST_P0: p0_d = pins;
        ST_P1: begin
          md_d    = pins[PIN_LEFT] & pins[PIN_RIGHT];
          a_d     = pins[PIN_6];
          start_d = pins[PIN_9];
          up1_d   = pins[PIN_UP];
          down1_d = pins[PIN_DOWN];
        end
        ST_P5: six_d = &pins[3:0];
        ST_P6: begin
          if (six_q) ext_d = pins[3:0];
          else       ext_d = ext_q;
        end
        default: p0_d = p0_q;
      endcase
    end else begin
      p0_d = p0_q;
    end
  end

  // Shadow register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q    <= 6'h00;
      md_q    <= 1'b0;
      a_q     <= 1'b0;
      start_q <= 1'b0;
      up1_q   <= 1'b0;
      down1_q <= 1'b0;
      six_q   <= 1'b0;
      ext_q   <= 4'h0;
    end else begin
      p0_q    <= p0_d;
      md_q    <= md_d;
      a_q     <= a_d;
      start_q <= start_d;
      up1_q   <= up1_d;
      down1_q <= down1_d;
      six_q   <= six_d;
      ext_q   <= ext_d;
    end
  end

  assign ext_s = (md_q & six_q) ? ext_q : 4'h0;
  assign six   = md_q & six_q;

  // With SELECT low an MD pad grounds left/right, so up/down are trusted from P1 instead.
  always_comb begin
    word              = 16'h0000;
    word[JOY_R]       = p0_q[PIN_RIGHT];
    word[JOY_L]       = p0_q[PIN_LEFT];
    word[JOY_D]       = md_q ? down1_q : p0_q[PIN_DOWN];
    word[JOY_U]       = md_q ? up1_q : p0_q[PIN_UP];
    word[JOY_B]       = p0_q[PIN_6];
    word[JOY_C]       = p0_q[PIN_9];
    word[JOY_A]       = md_q & a_q;
    word[JOY_START]   = md_q & start_q;
    word[JOY_Z]       = ext_s[PIN_UP];
    word[JOY_Y]       = ext_s[PIN_DOWN];
    word[JOY_X]       = ext_s[PIN_LEFT];
    word[JOY_MODE]    = ext_s[PIN_RIGHT];
  end

endmodule

// File: rtl/joy_db9md_reader.sv
// Two-port DB9 Mega Drive joystick scanner sharing one SELECT line.
// It publishes active-high button words once per scan, and all of its outputs are registered.
module joy_db9md_reader
  import joy_db9md_pkg::*;
#(
  parameter int STEP_DIV   = 70,
  parameter int SCAN_STEPS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  db9_1,
  input  logic [5:0]  db9_2,
  output logic        db9_sel,
  output logic [15:0] joy1,
  output logic [15:0] joy2,
  output logic        pad6_1,
  output logic        pad6_2,
  output logic        scan_done
);

  localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int STEP_W = $clog2(SCAN_STEPS);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] step_q, step_d;
  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [15:0]       joy1_q, joy1_d, joy2_q, joy2_d;
  logic              pad6_1_q, pad6_1_d, pad6_2_q, pad6_2_d;
  logic              done_q, done_d;
  logic [5:0]        meta1_q, sync1_q, meta2_q, sync2_q;
  logic              step_tick;
  logic              clr_s;
  logic [15:0]       word1_s, word2_s;
  logic              six1_s, six2_s;

  assign step_tick = (div_q == DIV_W'(STEP_DIV - 1));

  // Step divider, phase sequencing and output load.
  always_comb begin
    div_d    = step_tick ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    state_d  = state_q;
    step_d   = step_q;
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    pad6_1_d = pad6_1_q;
    pad6_2_d = pad6_2_q;
    done_d   = 1'b0;
    clr_s    = 1'b0;
    if (step_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (step_q == STEP_W'(SCAN_STEPS - 9)) begin
            state_d = ST_P0;
            step_d  = {STEP_W{1'b0}};
            clr_s   = 1'b1;
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        ST_P0: state_d = ST_P1;
        ST_P1: state_d = ST_P2;
        ST_P2: state_d = ST_P3;
        ST_P3: state_d = ST_P4;
        ST_P4: state_d = ST_P5;
        ST_P5: state_d = ST_P6;
        ST_P6: state_d = ST_P7;
        ST_P7: begin
          state_d  = ST_IDLE;
          joy1_d   = word1_s;
          joy2_d   = word2_s;
          pad6_1_d = six1_s;
          pad6_2_d = six2_s;
          done_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    case (state_d)
      ST_P1, ST_P3, ST_P5, ST_P7: sel_d = 1'b0;
      default:                    sel_d = 1'b1;
    endcase
  end

  // Phase FSM with its registered outputs and the pin synchronizers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= {DIV_W{1'b0}};
      step_q   <= {STEP_W{1'b0}};
      state_q  <= ST_IDLE;
      sel_q    <= 1'b1;
      joy1_q   <= 16'h0000;
      joy2_q   <= 16'h0000;
      pad6_1_q <= 1'b0;
      pad6_2_q <= 1'b0;
      done_q   <= 1'b0;
      meta1_q  <= 6'h3F;
      sync1_q  <= 6'h3F;
      meta2_q  <= 6'h3F;
      sync2_q  <= 6'h3F;
    end else begin
      div_q    <= div_d;
      step_q   <= step_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      joy1_q   <= joy1_d;
      joy2_q   <= joy2_d;
      pad6_1_q <= pad6_1_d;
      pad6_2_q <= pad6_2_d;
      done_q   <= done_d;
      meta1_q  <= db9_1;
      sync1_q  <= meta1_q;
      meta2_q  <= db9_2;
      sync2_q  <= meta2_q;
    end
  end

  db9md_port_decode u_port1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .strobe (step_tick),
    .phase  (state_q),
    .pins   (~sync1_q),
    .word   (word1_s),
    .six    (six1_s)
  );

  db9md_port_decode u_port2 (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .strobe (step_tick),
    .phase  (state_q),
    .pins   (~sync2_q),
    .word   (word2_s),
    .six    (six2_s)
  );

  assign db9_sel   = sel_q;
  assign joy1      = joy1_q;
  assign joy2      = joy2_q;
  assign pad6_1    = pad6_1_q;
  assign pad6_2    = pad6_2_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_joy_db9md_reader.sv
// Directed bench for joy_db9md_reader: models none/Atari/3-button/6-button pads on both ports
// and checks SELECT timing, decoded words and reset behaviour.
module tb_joy_db9md_reader;

  localparam int STEP_DIV   = 4;
  localparam int SCAN_STEPS = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  db9_1, db9_2;
  logic        db9_sel, pad6_1, pad6_2, scan_done;
  logic [15:0] joy1, joy2;

  logic [1:0]  t1 = 2'd0, t2 = 2'd0;
  logic [11:0] b1 = 12'h000, b2 = 12'h000;
  logic [5:0]  r1 = 6'h3F, r2 = 6'h3F;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int hi_cnt = 0;
  logic sel_prev = 1'b1;

  typedef struct {
    logic [1:0]  t1;
    logic [11:0] b1;
    logic [5:0]  r1;
    logic [1:0]  t2;
    logic [11:0] b2;
    logic [5:0]  r2;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        p1;
    logic        p2;
  } vec_t;

  vec_t vecs[6];

  joy_db9md_reader #(.STEP_DIV(STEP_DIV), .SCAN_STEPS(SCAN_STEPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .db9_1     (db9_1),
    .db9_2     (db9_2),
    .db9_sel   (db9_sel),
    .joy1      (joy1),
    .joy2      (joy2),
    .pad6_1    (pad6_1),
    .pad6_2    (pad6_2),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  // Pad model: t 0 = nothing, 1 = raw Atari pins, 2 = 3-button, 3 = 6-button.
  function automatic logic [5:0] pad_pins(input logic [1:0] t, input logic sel, input int cnt,
                                          input logic [11:0] b, input logic [5:0] raw);
    logic [5:0] p;
    logic [5:0] r;
    p = 6'h00;
    case (t)
      2'd0: r = 6'h3F;
      2'd1: r = raw;
      default: begin
        if (sel) begin
          if (t == 2'd3 && cnt == 3) p = {b[5], b[4], b[11], b[10], b[9], b[8]};
          else                       p = {b[5], b[4], b[0], b[1], b[2], b[3]};
        end else begin
          if (t == 2'd3 && cnt == 3) p = {b[7], b[6], 4'b1111};
          else                       p = {b[7], b[6], 2'b11, b[2], b[3]};
        end
        r = ~p;
      end
    endcase
    return r;
  endfunction

  assign db9_1 = pad_pins(t1, db9_sel, edge_cnt, b1, r1);
  assign db9_2 = pad_pins(t2, db9_sel, edge_cnt, b2, r2);

  // 6-button pad counter: counts SELECT falling edges, clears after a long high period.
  always @(posedge clk) begin
    sel_prev <= db9_sel;
    if (db9_sel) begin
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt >= 16) edge_cnt <= 0;
    end else begin
      hi_cnt <= 0;
      if (sel_prev) edge_cnt <= edge_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_scan(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (scan_done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      total++;
      bad++;
      $display("FAIL scan_timeout: got no scan_done, expected one within 1000 clk");
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] j1, input logic [15:0] j2,
                            input logic p1, input logic p2);
    check({tag, "_joy1"}, joy1, j1);
    check({tag, "_joy2"}, joy2, j2);
    check({tag, "_pad6_1"}, {15'h0, pad6_1}, {15'h0, p1});
    check({tag, "_pad6_2"}, {15'h0, pad6_2}, {15'h0, p2});
  endtask

  initial begin
    int   cyc;
    int   sel_bad;
    int   done_cnt;
    int   done_first;
    int   done_second;
    int   changed;
    int   ph;
    logic exp_sel;

    vecs[0] = '{2'd2, 12'h0C8, 6'h3F, 2'd0, 12'h000, 6'h3F, 16'h00C8, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{2'd3, 12'hC01, 6'h3F, 2'd2, 12'hC01, 6'h3F, 16'h0C01, 16'h0001, 1'b1, 1'b0};
    vecs[2] = '{2'd0, 12'h000, 6'h3F, 2'd1, 12'h000, 6'b101011, 16'h0000, 16'h0012, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 12'hFFF, 6'h3F, 2'd2, 12'h036, 6'h3F, 16'h0FFF, 16'h0036, 1'b1, 1'b0};
    vecs[4] = '{2'd1, 12'h000, 6'b010110, 2'd3, 12'h390, 6'h3F, 16'h0029, 16'h0390, 1'b0, 1'b1};
    vecs[5] = '{2'd3, 12'h000, 6'h3F, 2'd0, 12'h000, 6'h3F, 16'h0000, 16'h0000, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", {15'h0, db9_sel}, 16'h0001);
    check("rst_done", {15'h0, scan_done}, 16'h0000);
    check_outs("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // SELECT pattern: 192 idle steps high, then 1,0,1,0,1,0,1,0 per 4-clk phase, period 800 clk.
    @(negedge clk);
    rst = 1'b0;
    sel_bad = 0;
    done_cnt = 0;
    done_first = -1;
    done_second = -1;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #1;
      exp_sel = 1'b1;
      if (i >= 767) begin
        ph = (i - 767) % 800;
        if (ph < 32) exp_sel = ((ph / 4) % 2 == 0);
      end
      if (db9_sel !== exp_sel) sel_bad++;
      if (scan_done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_first = i;
        if (done_cnt == 2) done_second = i;
      end
    end
    check("sel_pattern_errors", sel_bad[15:0], 16'd0);
    check("scan_done_count", done_cnt[15:0], 16'd2);
    check("scan_done_first", done_first[15:0], 16'd799);
    check("scan_done_second", done_second[15:0], 16'd1599);

    foreach (vecs[k]) begin
      t1 = vecs[k].t1; b1 = vecs[k].b1; r1 = vecs[k].r1;
      t2 = vecs[k].t2; b2 = vecs[k].b2; r2 = vecs[k].r2;
      wait_scan(cyc);
      check_outs($sformatf("vec%0d", k), vecs[k].j1, vecs[k].j2, vecs[k].p1, vecs[k].p2);
    end

    // Press A during P3: the scan in progress already sampled P1, so A shows one scan later.
    t1 = 2'd2; b1 = 12'h008; t2 = 2'd0;
    wait_scan(cyc);
    check("p3_before", joy1, 16'h0008);
    repeat (782) @(posedge clk);
    b1 = 12'h048;
    changed = 0;
    cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (scan_done === 1'b1) begin
        cyc = i;
        break;
      end
      if (joy1 !== 16'h0008) changed++;
    end
    check("p3_midscan_changes", changed[15:0], 16'd0);
    check("p3_done_seen", {15'h0, (cyc >= 0)}, 16'h0001);
    check("p3_same_scan", joy1, 16'h0008);
    wait_scan(cyc);
    check("p3_next_scan", joy1, 16'h0048);

    // Reset asserted during P4 aborts the scan.
    t1 = 2'd3; b1 = 12'hC01; t2 = 2'd2; b2 = 12'h0C0;
    wait_scan(cyc);
    check_outs("pre_rst", 16'h0C01, 16'h00C0, 1'b1, 1'b0);
    repeat (786) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outs("mid_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("mid_rst_sel", {15'h0, db9_sel}, 16'h0001);
    check("mid_rst_done", {15'h0, scan_done}, 16'h0000);
    @(posedge clk);
    #1;
    check("mid_rst_done2", {15'h0, scan_done}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    wait_scan(cyc);
    check("post_rst_latency", cyc[15:0], 16'd800);
    check_outs("post_rst", 16'h0C01, 16'h00C0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
    $fatal(1);
  end

endmodule
